adc_sampler: RTL and testbench

ADC_SAMPLER -- requirements
Module: adc_sampler

---
 rtl/adc_sampler_if.sv | 9 +
 rtl/adc_sampler.sv | 135 +++++++++++++
 tb/tb_adc_sampler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/adc_sampler_if.sv
// adc_sampler_if: serial bus between the sampler (master) and the ADC (slave)
interface adc_sampler_if;
  logic adc_cs_n;
  logic adc_sclk;
  logic adc_din;
  logic adc_dout;
  modport master (output adc_cs_n, adc_sclk, adc_din, input adc_dout);
  modport slave (input adc_cs_n, adc_sclk, adc_din, output adc_dout);
endinterface

// File: rtl/adc_sampler.sv
// adc_sampler: continuous serial ADC conversion loop with channel pipelining and registered outputs
module adc_sampler #(
  parameter int SCLK_DIV = 25,
  parameter int GAP = 50000
) (
  input  logic                s_clk,
  input  logic                s_rst,
  input  logic                en,
  input  logic [2:0]          ch,
  adc_sampler_if.master       adc,
  output logic [11:0]         vol,
  output logic [2:0]          vol_ch,
  output logic                con_end,
  output logic                busy
);
  localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);
  localparam logic [16:0] GAP_LAST = 17'(GAP - 1);
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_DONE, ST_GAP} state_t;
  state_t state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [3:0] bit_q, bit_d;
  logic [16:0] gap_q, gap_d;
  logic [15:0] shift_q, shift_d;
  logic [2:0] ch_cur_q, ch_cur_d, ch_prev_q, ch_prev_d;
  logic cs_n_q, cs_n_d, sclk_q, sclk_d, din_q, din_d;
  logic [11:0] vol_q, vol_d;
  logic [2:0] vol_ch_q, vol_ch_d;
  logic con_end_q, con_end_d, busy_q, busy_d;
  function automatic logic frame_bit(input logic [3:0] k, input logic [2:0] c);
    return (k == 4'd2) ? c[2] : (k == 4'd3) ? c[1] : (k == 4'd4) ? c[0] : 1'b0;
  endfunction
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    bit_d = bit_q;
    gap_d = gap_q;
    shift_d = shift_q;
    ch_cur_d = ch_cur_q;
    ch_prev_d = ch_prev_q;
    sclk_d = sclk_q;
    din_d = din_q;
    vol_d = vol_q;
    vol_ch_d = vol_ch_q;
    con_end_d = 1'b0;
    case (state_q)
      ST_IDLE: state_d = en ? ST_SETUP : ST_IDLE;
      ST_SETUP: begin
        div_d = div_q + 8'd1;
        if (div_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          div_d = 8'd0;
          ch_cur_d = ch;
          ch_prev_d = ch_cur_q;
          sclk_d = 1'b0;
          din_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        div_d = div_q + 8'd1;
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            shift_d = {shift_q[14:0], adc.adc_dout};
          end else if (bit_q == 4'd15) begin
            state_d = ST_DONE;
            bit_d = 4'd0;
            con_end_d = 1'b1;
            vol_d = shift_q[11:0];
            vol_ch_d = ch_prev_q;
          end else begin
            bit_d = bit_q + 4'd1;
            sclk_d = 1'b0;
            din_d = frame_bit(bit_q + 4'd1, ch_cur_q);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_GAP;
        gap_d = 17'd0;
      end
      ST_GAP: begin
        gap_d = gap_q + 17'd1;
        if (gap_q == GAP_LAST) begin
          gap_d = 17'd0;
          state_d = en ? ST_SETUP : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // chip select and busy follow the state being entered so they stay registered
    cs_n_d = !(state_d == ST_SETUP || state_d == ST_SHIFT);
    busy_d = !cs_n_d;
  end
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q <= ST_IDLE;
      div_q <= '0;
      bit_q <= '0;
      gap_q <= '0;
      shift_q <= '0;
      ch_cur_q <= '0;
      ch_prev_q <= '0;
      cs_n_q <= 1'b1;
      sclk_q <= 1'b1;
      din_q <= 1'b0;
      vol_q <= '0;
      vol_ch_q <= '0;
      con_end_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      bit_q <= bit_d;
      gap_q <= gap_d;
      shift_q <= shift_d;
      ch_cur_q <= ch_cur_d;
      ch_prev_q <= ch_prev_d;
      cs_n_q <= cs_n_d;
      sclk_q <= sclk_d;
      din_q <= din_d;
      vol_q <= vol_d;
      vol_ch_q <= vol_ch_d;
      con_end_q <= con_end_d;
      busy_q <= busy_d;
    end
  end
  assign adc.adc_cs_n = cs_n_q;
  assign adc.adc_sclk = sclk_q;
  assign adc.adc_din = din_q;
  assign vol = vol_q;
  assign vol_ch = vol_ch_q;
  assign con_end = con_end_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler: directed vectors against a behavioural serial ADC model
module tb_adc_sampler;
  localparam int SCLK_DIV = 2;
  localparam int GAP = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [2:0] ch = 3'd0;
  logic [11:0] vol;
  logic [2:0] vol_ch;
  logic con_end, busy;
  int tests = 0;
  int fails = 0;
  adc_sampler_if adc();
  adc_sampler #(.SCLK_DIV(SCLK_DIV), .GAP(GAP)) dut (
    .s_clk(clk), .s_rst(rst), .en(en), .ch(ch), .adc(adc),
    .vol(vol), .vol_ch(vol_ch), .con_end(con_end), .busy(busy)
  );
  always #5 clk = ~clk;
  logic [15:0] word = 16'h0;
  logic [15:0] sh = 16'h0;
  logic [15:0] rx = 16'h0;
  initial adc.adc_dout = 1'b0;
  always @(negedge adc.adc_cs_n) begin
    sh = word;
    rx = 16'h0;
  end
  always @(negedge adc.adc_sclk) if (!adc.adc_cs_n) begin
    adc.adc_dout = sh[15];
    sh = {sh[14:0], 1'b0};
  end
  always @(posedge adc.adc_sclk) if (!adc.adc_cs_n) rx = {rx[14:0], adc.adc_din};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_frame(input int limit, output bit got, output int ncyc, output int nlow,
                            output int nfall, output bit bbad);
    logic ps;
    got = 1'b0; ncyc = 0; nlow = 0; nfall = 0; bbad = 1'b0;
    ps = adc.adc_sclk;
    while (!got && ncyc < limit) begin
      @(negedge clk);
      ncyc++;
      if (!adc.adc_cs_n) nlow++;
      if (ps && !adc.adc_sclk) nfall++;
      ps = adc.adc_sclk;
      if (busy !== ~adc.adc_cs_n) bbad = 1'b1;
      got = con_end;
    end
  endtask
  typedef struct {
    logic [2:0] ch;
    logic [15:0] word;
    logic [11:0] vol;
    logic [2:0] vch;
  } vec_t;
  vec_t vt[5];
  initial begin
    bit got, bbad;
    int ncyc, nlow, nfall, bad, nf, k;
    logic ps;
    vt[0] = '{3'd0, 16'h0ABC, 12'hABC, 3'd0};
    vt[1] = '{3'd5, 16'h1234, 12'h234, 3'd0};
    vt[2] = '{3'd3, 16'hFFFF, 12'hFFF, 3'd5};
    vt[3] = '{3'd7, 16'h8001, 12'h001, 3'd3};
    vt[4] = '{3'd2, 16'hA5A5, 12'h5A5, 3'd7};
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(adc.adc_cs_n), 32'd1);
    chk("rst_sclk", 32'(adc.adc_sclk), 32'd1);
    chk("rst_din", 32'(adc.adc_din), 32'd0);
    chk("rst_vol", 32'(vol), 32'd0);
    chk("rst_vol_ch", 32'(vol_ch), 32'd0);
    chk("rst_con_end", 32'(con_end), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    ch = vt[0].ch;
    word = vt[0].word;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_frame(300, got, ncyc, nlow, nfall, bbad);
      chk($sformatf("con_end[%0d]", i), 32'(got), 32'd1);
      chk($sformatf("vol[%0d]", i), 32'(vol), 32'(vt[i].vol));
      chk($sformatf("vol_ch[%0d]", i), 32'(vol_ch), 32'(vt[i].vch));
      chk($sformatf("din_ch[%0d]", i), 32'(rx[13:11]), 32'(vt[i].ch));
      chk($sformatf("cs_low[%0d]", i), 32'(nlow), 32'd66);
      chk($sformatf("sclk_falls[%0d]", i), 32'(nfall), 32'd16);
      chk($sformatf("busy[%0d]", i), 32'(bbad), 32'd0);
      if (i > 0) chk($sformatf("period[%0d]", i), 32'(ncyc), 32'd71);
      if (i < 4) begin
        ch = vt[i + 1].ch;
        word = vt[i + 1].word;
      end else begin
        ch = 3'd4;
        word = 16'h0123;
      end
    end
    repeat (30) @(negedge clk);
    en = 1'b0;
    wait_frame(300, got, ncyc, nlow, nfall, bbad);
    chk("drop_con_end", 32'(got), 32'd1);
    chk("drop_vol", 32'(vol), 32'h123);
    chk("drop_vol_ch", 32'(vol_ch), 32'd2);
    chk("drop_din_ch", 32'(rx[13:11]), 32'd4);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (!adc.adc_cs_n || con_end || busy) bad++;
    end
    chk("idle_hold", 32'(bad), 32'd0);
    chk("idle_vol_hold", 32'(vol), 32'h123);
    en = 1'b1;
    @(negedge clk);
    chk("idle_restart", 32'(adc.adc_cs_n), 32'd0);
    nf = 0;
    k = 0;
    ps = adc.adc_sclk;
    while (nf < 8 && k < 300) begin
      @(negedge clk);
      k++;
      if (ps && !adc.adc_sclk) nf++;
      ps = adc.adc_sclk;
    end
    chk("reach_bit7", 32'(nf), 32'd8);
    rst = 1'b1;
    #1;
    chk("arst_cs_n", 32'(adc.adc_cs_n), 32'd1);
    chk("arst_sclk", 32'(adc.adc_sclk), 32'd1);
    chk("arst_din", 32'(adc.adc_din), 32'd0);
    chk("arst_vol", 32'(vol), 32'd0);
    chk("arst_vol_ch", 32'(vol_ch), 32'd0);
    chk("arst_con_end", 32'(con_end), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    ch = 3'd6;
    word = 16'h0F0F;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (con_end) bad++;
    end
    chk("arst_no_con_end", 32'(bad), 32'd0);
    rst = 1'b0;
    wait_frame(300, got, ncyc, nlow, nfall, bbad);
    chk("post_con_end", 32'(got), 32'd1);
    chk("post_vol", 32'(vol), 32'hF0F);
    chk("post_vol_ch", 32'(vol_ch), 32'd0);
    chk("post_din_ch", 32'(rx[13:11]), 32'd6);
    chk("post_cs_low", 32'(nlow), 32'd66);
    chk("post_sclk_falls", 32'(nfall), 32'd16);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
